// File: rtl/sample_iterator.sv
// Raster sample iterator: walks a pixel-snapped bounding box at the MSAA step, one sample per cycle.
// Optional SAMPLE_ITER_STATS_EN adds a saturating per-sample counter output (sampCount_R14U).
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]            color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]              box_R13S,
  input  logic                                            validTri_R13H,
  input  logic        [3:0]                               subSample_RnnnnU,
  output logic                                            halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]            color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                   sample_R14S,
  output logic                                            validSamp_R14H
`ifdef SAMPLE_ITER_STATS_EN
  ,
  output logic        [31:0]                              sampCount_R14U
`endif
);

  localparam logic [0:0] WAIT = 1'b0;
  localparam logic [0:0] TEST = 1'b1;

  logic [0:0]                                    r_state;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic        [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic signed [1:0][SIGFIG-1:0]                 r_sample;
  logic signed [SIGFIG-1:0]                      r_llx;
  logic signed [SIGFIG-1:0]                      r_urx;
  logic signed [SIGFIG-1:0]                      r_ury;
  logic        [SIGFIG-1:0]                      r_step;
  logic                                          r_valid;
  logic                                          r_halt;

  logic signed [SIGFIG:0] w_x_ext;
  logic signed [SIGFIG:0] w_y_ext;
  logic signed [SIGFIG:0] w_urx_ext;
  logic signed [SIGFIG:0] w_ury_ext;
  logic signed [SIGFIG:0] w_step_ext;
  logic signed [SIGFIG:0] w_nx;
  logic signed [SIGFIG:0] w_ny;
  logic                   w_x_done;
  logic                   w_y_done;

  // Non-one-hot modes fall back to one sample per pixel.
  function automatic logic [SIGFIG-1:0] step_for(input logic [3:0] sub);
    logic [SIGFIG-1:0] one;
    one = SIGFIG'(1) << RADIX;
    case (sub)
      4'b1000: step_for = one;
      4'b0100: step_for = one >> 1;
      4'b0010: step_for = one >> 2;
      4'b0001: step_for = one >> 3;
      default: step_for = one;
    endcase
  endfunction

  // One guard bit keeps x+step from wrapping near the positive coordinate limit.
  assign w_x_ext    = $signed({r_sample[0][SIGFIG-1], r_sample[0]});
  assign w_y_ext    = $signed({r_sample[1][SIGFIG-1], r_sample[1]});
  assign w_urx_ext  = $signed({r_urx[SIGFIG-1], r_urx});
  assign w_ury_ext  = $signed({r_ury[SIGFIG-1], r_ury});
  assign w_step_ext = $signed({1'b0, r_step});
  assign w_nx       = w_x_ext + w_step_ext;
  assign w_ny       = w_y_ext + w_step_ext;
  assign w_x_done   = (w_nx > w_urx_ext);
  assign w_y_done   = (w_ny > w_ury_ext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= WAIT;
      r_tri    <= '0;
      r_color  <= '0;
      r_sample <= '0;
      r_llx    <= '0;
      r_urx    <= '0;
      r_ury    <= '0;
      r_step   <= '0;
      r_valid  <= 1'b0;
      r_halt   <= 1'b1;
    end else begin
      case (r_state)
        WAIT: begin
          if (validTri_R13H) begin
            r_tri       <= tri_R13S;
            r_color     <= color_R13U;
            r_llx       <= box_R13S[0][0];
            r_urx       <= box_R13S[1][0];
            r_ury       <= box_R13S[1][1];
            r_sample[0] <= box_R13S[0][0];
            r_sample[1] <= box_R13S[0][1];
            r_step      <= step_for(subSample_RnnnnU);
            r_valid     <= 1'b1;
            r_halt      <= 1'b0;
            r_state     <= TEST;
          end
        end
        TEST: begin
          if (w_x_done) begin
            if (w_y_done) begin
              r_valid <= 1'b0;
              r_halt  <= 1'b1;
              r_state <= WAIT;
            end else begin
              r_sample[0] <= r_llx;
              r_sample[1] <= w_ny[SIGFIG-1:0];
            end
          end else begin
            r_sample[0] <= w_nx[SIGFIG-1:0];
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_halt  <= 1'b1;
          r_state <= WAIT;
        end
      endcase
    end
  end

  assign halt_RnnnnL    = r_halt;
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S    = r_sample;
  assign validSamp_R14H = r_valid;

`ifdef SAMPLE_ITER_STATS_EN
  logic [31:0] r_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (r_valid) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign sampCount_R14U = r_count;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Directed, table-driven bench for sample_iterator; checks counts, raster order, handshake and reset.
module tb_sample_iterator;

  logic                          clk = 1'b0;
  logic                          rst;
  logic signed [2:0][2:0][23:0]  tri_in;
  logic        [2:0][23:0]       col_in;
  logic signed [1:0][1:0][23:0]  box_in;
  logic                          vt;
  logic        [3:0]             sub;
  logic                          halt;
  logic signed [2:0][2:0][23:0]  tri_out;
  logic        [2:0][23:0]       col_out;
  logic signed [1:0][23:0]       samp;
  logic                          vs;
`ifdef SAMPLE_ITER_STATS_EN
  logic        [31:0]            scnt;
`endif

  sample_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (col_in),
    .box_R13S         (box_in),
    .validTri_R13H    (vt),
    .subSample_RnnnnU (sub),
    .halt_RnnnnL      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (col_out),
    .sample_R14S      (samp),
    .validSamp_R14H   (vs)
`ifdef SAMPLE_ITER_STATS_EN
    ,
    .sampCount_R14U   (scnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    int llx, lly, urx, ury;
    int n, lx, ly;
  } vec_t;

  vec_t tv[9];
  int   n_chk = 0;
  int   n_fail = 0;
  int   sx[$];
  int   sy[$];
  int   halt_low, tri_bad, done;
  logic signed [2:0][2:0][23:0] exp_tri;
  logic        [2:0][23:0]      exp_col;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int xs(input int i);
    return (i >= 0 && i < sx.size()) ? sx[i] : 32'h7fffffff;
  endfunction

  function automatic int ys(input int i);
    return (i >= 0 && i < sy.size()) ? sy[i] : 32'h7fffffff;
  endfunction

  task automatic set_tri(input int seed);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_in[v][a] = 24'(seed * 16 + v * 4 + a);
    for (int c = 0; c < 3; c++) col_in[c] = 24'(seed * 7 + c + 1);
  endtask

  task automatic start(input logic [3:0] s, input int llx, input int lly,
                       input int urx, input int ury, input int seed);
    @(negedge clk);
    chk("ready_before_start", halt, 1);
    sub = s;
    box_in[0][0] = 24'(llx);
    box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx);
    box_in[1][1] = 24'(ury);
    set_tri(seed);
    vt = 1'b1;
    @(posedge clk);
    #1;
    vt = 1'b0;
    exp_tri = tri_in;
    exp_col = col_in;
    set_tri(seed + 99);
    sub = 4'b0001;
    box_in = '1;
  endtask

  task automatic collect(input int budget);
    sx.delete();
    sy.delete();
    halt_low = 0;
    tri_bad = 0;
    done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!halt) halt_low++;
      if (!vs) begin
        done = 1;
        break;
      end
      sx.push_back(int'($signed(samp[0])));
      sy.push_back(int'($signed(samp[1])));
      if (tri_out !== exp_tri || col_out !== exp_col) tri_bad++;
    end
    chk("terminated", done, 1);
    chk("halt_after", halt, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    tv[0] = '{4'b1000, 0, 0, 1024, 1024, 4, 1024, 1024};
    tv[1] = '{4'b0100, 0, 0, 1024, 0, 3, 1024, 0};
    tv[2] = '{4'b0100, 2048, 3072, 2048, 3072, 1, 2048, 3072};
    tv[3] = '{4'b0010, 0, 0, 1023, 255, 4, 768, 0};
    tv[4] = '{4'b0001, -256, -128, 0, 0, 6, 0, 0};
    tv[5] = '{4'b0000, 0, 0, 2047, 1024, 4, 1024, 1024};
    tv[6] = '{4'b1100, 0, 0, 1023, 0, 1, 0, 0};
    tv[7] = '{4'b1000, 8386560, 8388607, 8388607, 8388607, 2, 8387584, 8388607};
    tv[8] = '{4'b0001, 0, 0, 128, 128, 4, 128, 128};

    rst = 1'b0;
    vt = 1'b0;
    sub = 4'b1000;
    box_in = '0;
    set_tri(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", vs, 0);
    chk("rst_halt", halt, 1);
    chk("rst_sample", samp, 0);
    chk("rst_tri_zero", (tri_out == '0) ? 1 : 0, 1);
    chk("rst_color_zero", (col_out == '0) ? 1 : 0, 1);
`ifdef SAMPLE_ITER_STATS_EN
    chk("rst_count", scnt, 0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start(tv[i].s, tv[i].llx, tv[i].lly, tv[i].urx, tv[i].ury, i + 2);
      collect(200);
      chk($sformatf("v%0d_count", i), sx.size(), tv[i].n);
      chk($sformatf("v%0d_first_x", i), xs(0), tv[i].llx);
      chk($sformatf("v%0d_first_y", i), ys(0), tv[i].lly);
      chk($sformatf("v%0d_last_x", i), xs(sx.size() - 1), tv[i].lx);
      chk($sformatf("v%0d_last_y", i), ys(sy.size() - 1), tv[i].ly);
      chk($sformatf("v%0d_halt_low", i), halt_low, tv[i].n);
      chk($sformatf("v%0d_tri_hold", i), tri_bad, 0);
      if (i == 0) begin
        chk("v0_s1", xs(1) * 100000 + ys(1), 1024 * 100000 + 0);
        chk("v0_s2", xs(2) * 100000 + ys(2), 0 * 100000 + 1024);
      end
      if (i == 1) begin
        chk("v1_mid_x", xs(1), 512);
        chk("v1_mid_y", ys(1), 0);
`ifdef SAMPLE_ITER_STATS_EN
        chk("stats_count7", scnt, 7);
`endif
      end
    end

    // Second triangle held high through TEST; accepted on the first WAIT cycle.
    @(negedge clk);
    sub = 4'b1000;
    box_in[0][0] = 24'(0);    box_in[0][1] = 24'(0);
    box_in[1][0] = 24'(1024); box_in[1][1] = 24'(1024);
    vt = 1'b1;
    @(posedge clk);
    #1;
    sub = 4'b0100;
    box_in[1][0] = 24'(512);
    box_in[1][1] = 24'(0);
    held = 1;
    sx.delete();
    sy.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vs) begin
        sx.push_back(int'($signed(samp[0])));
        sy.push_back(int'($signed(samp[1])));
      end
      if (held == 1 && halt) begin
        @(posedge clk);
        #1;
        vt = 1'b0;
        held = 0;
      end
    end
    chk("bp_accepted", held, 0);
    chk("bp_count", sx.size(), 6);
    chk("bp_a_last_x", xs(3), 1024);
    chk("bp_a_last_y", ys(3), 1024);
    chk("bp_b_first_x", xs(4), 0);
    chk("bp_b_second_x", xs(5), 512);
    chk("bp_b_second_y", ys(5), 0);

    // Reset on the second sample of a 16-sample triangle.
    start(4'b0010, 0, 0, 768, 768, 40);
    @(negedge clk);
    chk("rm_first_valid", vs, 1);
    @(negedge clk);
    chk("rm_second_x", int'($signed(samp[0])), 256);
    #1;
    rst = 1'b0;
    #1;
    chk("rm_valid_now", vs, 0);
    chk("rm_halt_now", halt, 1);
    chk("rm_sample_zero", samp, 0);
`ifdef SAMPLE_ITER_STATS_EN
    chk("rm_count_zero", scnt, 0);
`endif
    @(negedge clk);
    chk("rm_valid_held", vs, 0);
    rst = 1'b1;
    start(4'b1000, 2048, 2048, 3072, 2048, 50);
    collect(50);
    chk("rm_new_count", sx.size(), 2);
    chk("rm_new_first_x", xs(0), 2048);
    chk("rm_new_first_y", ys(0), 2048);
    chk("rm_new_second_x", xs(1), 3072);
`ifdef SAMPLE_ITER_STATS_EN
    chk("rm_new_stats", scnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_iterator.md
SAMPLE_ITERATOR -- requirements
Module: sample_iterator

Interface
REQ-001 SHALL expose parameters: SIGFIG 24 (bits in position/color); RADIX 10 (fraction bits); VERTS 3 (triangle vertices); AXIS 3 (x,y,z); COLORS 3 (color channels).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: tri_R13S  input  signed VERTSxAXISxSIGFIG  triangle vertices.
REQ-005 SHALL have port: color_R13U  input  unsigned COLORSxSIGFIG  triangle color.
REQ-006 SHALL have port: box_R13S  input  signed 2x2xSIGFIG  bounding box, [0]=lower-left, [1]=upper-right, [i][0]=x, [i][1]=y, inclusive, pixel-snapped.
REQ-007 SHALL have port: validTri_R13H  input  1  triangle/box valid.
REQ-008 SHALL have port: subSample_RnnnnU  input  4  one-hot MSAA mode: 1000=1x, 0100=4x, 0010=16x, 0001=64x.
REQ-009 SHALL have port: halt_RnnnnL  output  1  high = ready to accept triangle; low = upstream holds.
REQ-010 SHALL have port: tri_R14S / color_R14U  output  same shapes as inputs  latched triangle/color.
REQ-011 SHALL have port: sample_R14S  output  signed 2xSIGFIG  sample x,y.
REQ-012 SHALL have port: validSamp_R14H  output  1  sample_R14S valid this cycle.

Function
REQ-013 SHALL implement two-state FSM: WAIT (idle) and TEST (iterating).
REQ-014 In WAIT, halt_RnnnnL SHALL be 1 and validSamp_R14H SHALL be 0.
REQ-015 In WAIT, when validTri_R13H=1, the block SHALL, on that edge, latch tri, color and box, set sample_R14S = box lower-left, assert validSamp_R14H, drive halt_RnnnnL=0 and enter TEST. First sample appears one cycle after acceptance.
REQ-016 Step SHALL be (1<<RADIX)>>k, with k=0,1,2,3 for 1x,4x,16x,64x; non-one-hot subSample_RnnnnU SHALL be treated as 1x; subSample_RnnnnU SHALL be sampled only at acceptance.
REQ-017 In TEST, each cycle SHALL emit one sample, raster order: x increments by step; if x+step > ur.x, then x = ll.x and y += step.
REQ-018 When x+step > ur.x and y+step > ur.y in the current cycle, that cycle SHALL be the last valid sample; next edge SHALL return to WAIT with validSamp_R14H=0 and halt_RnnnnL=1.
REQ-019 Sample count per triangle SHALL equal (floor((ur.x-ll.x)/step)+1) x (floor((ur.y-ll.y)/step)+1); ll==ur SHALL give exactly one sample.
REQ-020 Comparisons SHALL use SIGFIG+1-bit signed arithmetic so x+step never wraps at the positive coordinate limit.
REQ-021 validTri_R13H in TEST SHALL be ignored; no triangle is dropped because upstream holds while halt_RnnnnL=0.
REQ-022 tri_R14S and color_R14U SHALL stay constant for all samples of one triangle.
REQ-023 There SHALL be no back-to-back bubble beyond one: a triangle presented in the WAIT cycle after completion SHALL be accepted that cycle.

Reset
REQ-024 On rst=0, asynchronously: state=WAIT, validSamp_R14H=0, halt_RnnnnL=1, sample_R14S, tri_R14S, color_R14U, latched box and step all zero.
REQ-025 Reset mid-iteration SHALL abandon the triangle with no further samples; release SHALL resume in WAIT.

Configuration
REQ-026 Macro SAMPLE_ITER_STATS_EN defined: SHALL add output sampCount_R14U (32-bit unsigned), zeroed at reset, incremented each cycle validSamp_R14H=1, saturating at 2^32-1. Undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-027 1x, box ll=(0,0) ur=(1024,1024) -> samples (0,0),(1024,0),(0,1024),(1024,1024) on 4 consecutive cycles; halt low 4 cycles, high on the 5th.
REQ-028 4x, box ll=ur=(2048,3072) -> exactly one sample (2048,3072); halt low for exactly 1 cycle.
REQ-029 4x, box ll=(0,0) ur=(1024,0) -> x = 0,512,1024 at y=0; 3 samples.
REQ-030 Second triangle asserted during TEST, held until halt high -> accepted on first WAIT cycle; no samples lost or duplicated.
REQ-031 rst low on 2nd sample of a 16-sample triangle -> validSamp 0 immediately, halt 1; new triangle after release iterates from its own ll.
REQ-032 With SAMPLE_ITER_STATS_EN, run REQ-027 then REQ-029 -> sampCount_R14U = 7.
